// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, FSM states and bit-timing helpers
// used by the transmitter and the matching receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Zero-extending the word to 9 bits leaves its XOR reduction unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    logic even_s;
    even_s = ^data;
    case (mode)
      PAR_ODD:  parity_bit = ~even_s;
      PAR_EVEN: parity_bit = even_s;
      default:  parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles and flags the last cycle
// of each bit period; a synchronous clear restarts the period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic             tick,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Bit-period counter with clear and wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick = (cnt_r == CNT_LAST);
  assign cnt  = cnt_r;

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter draining a first-word-fall-through FIFO: one pop per frame,
// back-to-back frames with no idle gap while data is available.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_vld,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W        = 4;

  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] DATA_LAST    = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST    = BIT_W'(STOP_BITS - 1);

  uart_state_e       state_r;
  uart_state_e       state_next_s;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] shift_next_s;
  logic              par_r;
  logic              par_next_s;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [BIT_W-1:0]  bit_cnt_next_s;
  logic              tx_r;
  logic              tx_next_s;
  logic              busy_r;
  logic              frame_done_r;
  logic              frame_done_next_s;
  logic              pop_s;
  logic              clr_s;
  logic              tick_s;
  logic [CNT_W-1:0]  cnt_s;

  // Counter restarts on every state change and is held at zero while idle.
  assign clr_s = (state_r == ST_IDLE) || (state_next_s != state_r);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_s),
    .tick (tick_s),
    .cnt  (cnt_s)
  );

  // Next-state, bit counter, pop decision and word capture.
  always_comb begin
    state_next_s   = state_r;
    bit_cnt_next_s = bit_cnt_r;
    shift_next_s   = shift_r;
    par_next_s     = par_r;
    pop_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tx_en && fifo_rd_vld) begin
          pop_s        = 1'b1;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_next_s   = ST_DATA;
          bit_cnt_next_s = '0;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          shift_next_s = shift_r >> 1;
          if (bit_cnt_r == DATA_LAST) begin
            bit_cnt_next_s = '0;
            state_next_s   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next_s = bit_cnt_r + BIT_W'(1);
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick_s) begin
          state_next_s   = ST_STOP;
          bit_cnt_next_s = '0;
        end else begin
          state_next_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          if (bit_cnt_r == STOP_LAST) begin
            bit_cnt_next_s = '0;
            if (tx_en && fifo_rd_vld) begin
              pop_s        = 1'b1;
              state_next_s = ST_START;
            end else begin
              state_next_s = ST_IDLE;
            end
          end else begin
            bit_cnt_next_s = bit_cnt_r + BIT_W'(1);
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: begin
        state_next_s   = ST_IDLE;
        bit_cnt_next_s = '0;
      end
    endcase
    if (pop_s) begin
      shift_next_s = fifo_rd_data;
      par_next_s   = parity_bit(9'(fifo_rd_data), PARITY);
    end else begin
      par_next_s = par_next_s;
    end
  end

  // Line level for the cycle that follows, so tx leaves a flop.
  always_comb begin
    tx_next_s = 1'b1;
    case (state_next_s)
      ST_START:  tx_next_s = 1'b0;
      ST_DATA:   tx_next_s = shift_next_s[0];
      ST_PARITY: tx_next_s = par_next_s;
      default:   tx_next_s = 1'b1;
    endcase
  end

  // Registered one cycle early: the cycle after this one is the last stop cycle.
  assign frame_done_next_s = (state_r == ST_STOP) && (bit_cnt_r == STOP_LAST) &&
                             (cnt_s == CNT_PRE_LAST);

  // Frame state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      shift_r      <= '0;
      par_r        <= 1'b0;
      bit_cnt_r    <= '0;
      tx_r         <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      shift_r      <= shift_next_s;
      par_r        <= par_next_s;
      bit_cnt_r    <= bit_cnt_next_s;
      tx_r         <= tx_next_s;
      busy_r       <= (state_next_s != ST_IDLE);
      frame_done_r <= frame_done_next_s;
    end
  end

  // No pop may be issued while the transmitter is held in reset.
  assign fifo_rd_en = pop_s & rst_n;
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx at 10 clocks per bit: 8N1, 8E1 and 8O2
// instances, each fed from a small FWFT queue model.
module tb_uart_fifo_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       tx_en0, tx_en1, tx_en2;
  logic [7:0] data0, data1, data2;
  logic       vld0, vld1, vld2;
  logic       rd_en0, rd_en1, rd_en2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic       fd0, fd1, fd2;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic       pop0, pop1, pop2;
  int         tests;
  int         fails;

  uart_fifo_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en0), .fifo_rd_data(data0), .fifo_rd_vld(vld0),
    .fifo_rd_en(rd_en0), .tx(tx0), .busy(busy0), .frame_done(fd0));

  uart_fifo_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en1), .fifo_rd_data(data1), .fifo_rd_vld(vld1),
    .fifo_rd_en(rd_en1), .tx(tx1), .busy(busy1), .frame_done(fd1));

  uart_fifo_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en2), .fifo_rd_data(data2), .fifo_rd_vld(vld2),
    .fifo_rd_en(rd_en2), .tx(tx2), .busy(busy2), .frame_done(fd2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    vld0 = (q0.size() != 0);
    vld1 = (q1.size() != 0);
    vld2 = (q2.size() != 0);
    data0 = 8'h00;
    data1 = 8'h00;
    data2 = 8'h00;
    if (vld0) data0 = q0[0];
    if (vld1) data1 = q1[0];
    if (vld2) data2 = q2[0];
  endtask

  // Advance one clock: note pops at mid-cycle, land just after the edge.
  task automatic cyc();
    #4;
    pop0 = rd_en0;
    pop1 = rd_en1;
    pop2 = rd_en2;
    @(posedge clk);
    #1;
    if (pop0 && q0.size() != 0) void'(q0.pop_front());
    if (pop1 && q1.size() != 0) void'(q1.pop_front());
    if (pop2 && q2.size() != 0) void'(q2.pop_front());
    refresh();
  endtask

  task automatic sample(input int dut, output logic t, output logic b, output logic f, output logic p);
    case (dut)
      0:       begin t = tx0; b = busy0; f = fd0; p = pop0; end
      1:       begin t = tx1; b = busy1; f = fd1; p = pop1; end
      default: begin t = tx2; b = busy2; f = fd2; p = pop2; end
    endcase
  endtask

  // Walk one frame starting in the first cycle after its pop.
  task automatic run_frame(input int dut, input logic [7:0] d, input bit has_par, input logic par_exp,
                           input int stops, input logic pop_end, input int drop_at, input string tag);
    logic bits [0:11];
    int   nbits, len, err_tx, err_busy, err_fd, err_pop;
    logic t, b, f, p;
    nbits = 9 + (has_par ? 1 : 0) + stops;
    len   = nbits * 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (has_par) bits[9] = par_exp;
    for (int s = 0; s < stops; s++) bits[9 + (has_par ? 1 : 0) + s] = 1'b1;
    err_tx = 0; err_busy = 0; err_fd = 0; err_pop = 0;
    p = 1'b0;
    for (int k = 1; k <= len; k++) begin
      sample(dut, t, b, f, p);
      if (t !== bits[(k-1)/10]) err_tx++;
      if (b !== 1'b1) err_busy++;
      if (f !== (k == len)) err_fd++;
      if (k == 1) chk({tag, "_start_bit"}, 32'(t), 32'd0);
      if (k == len) chk({tag, "_frame_done"}, 32'(f), 32'd1);
      if (has_par && k == 95) chk({tag, "_parity_bit"}, 32'(t), 32'(par_exp));
      if (k == drop_at) tx_en0 = 1'b0;
      cyc();
      sample(dut, t, b, f, p);
      if (k < len && p) err_pop++;
    end
    chk({tag, "_tx_errs"}, 32'(err_tx), 32'd0);
    chk({tag, "_busy_errs"}, 32'(err_busy), 32'd0);
    chk({tag, "_done_errs"}, 32'(err_fd), 32'd0);
    chk({tag, "_extra_pops"}, 32'(err_pop), 32'd0);
    chk({tag, "_pop_at_end"}, 32'(p), 32'(pop_end));
  endtask

  initial begin
    int err;
    tests = 0; fails = 0;
    pop0 = 1'b0; pop1 = 1'b0; pop2 = 1'b0;
    tx_en0 = 1'b1; tx_en1 = 1'b1; tx_en2 = 1'b1;
    rst_n = 1'b1;
    refresh();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    cyc(); cyc();
    chk("reset_tx", 32'(tx0), 32'd1);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_rd_en", 32'(rd_en0), 32'd0);
    chk("reset_frame_done", 32'(fd0), 32'd0);
    chk("reset_tx_par", 32'(tx1 & tx2), 32'd1);
    rst_n = 1'b1;

    // Idle with empty FIFO.
    err = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || pop0) err++;
    end
    chk("idle_quiet", 32'(err), 32'd0);

    // Single word 0x55.
    q0.push_back(8'h55); refresh();
    cyc();
    chk("single_pop", 32'(pop0), 32'd1);
    run_frame(0, 8'h55, 1'b0, 1'b0, 1, 1'b0, 0, "single");
    chk("single_busy_after", 32'(busy0), 32'd0);

    // Three queued words back to back.
    q0.push_back(8'hA3); q0.push_back(8'h00); q0.push_back(8'hFF); refresh();
    cyc();
    chk("three_pop", 32'(pop0), 32'd1);
    run_frame(0, 8'hA3, 1'b0, 1'b0, 1, 1'b1, 0, "three_a3");
    run_frame(0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 0, "three_00");
    run_frame(0, 8'hFF, 1'b0, 1'b0, 1, 1'b0, 0, "three_ff");
    chk("three_busy_after", 32'(busy0), 32'd0);
    chk("three_fifo_empty", 32'(q0.size()), 32'd0);

    // Even parity of 0x07 is 1; odd parity is 0; two stop bits make 120 cycles.
    q1.push_back(8'h07); refresh();
    cyc();
    chk("even_pop", 32'(pop1), 32'd1);
    run_frame(1, 8'h07, 1'b1, 1'b1, 1, 1'b0, 0, "even");
    chk("even_busy_after", 32'(busy1), 32'd0);
    q2.push_back(8'h07); refresh();
    cyc();
    chk("odd_pop", 32'(pop2), 32'd1);
    run_frame(2, 8'h07, 1'b1, 1'b0, 2, 1'b0, 0, "odd2");
    chk("odd_busy_after", 32'(busy2), 32'd0);

    // tx_en dropped mid-frame: frame completes, nothing further popped.
    q0.push_back(8'h11); q0.push_back(8'h22); refresh();
    cyc();
    chk("drop_pop", 32'(pop0), 32'd1);
    run_frame(0, 8'h11, 1'b0, 1'b0, 1, 1'b0, 30, "drop");
    err = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (pop0 || busy0 !== 1'b0 || tx0 !== 1'b1) err++;
    end
    chk("drop_no_pop", 32'(err), 32'd0);
    chk("drop_word_kept", 32'(vld0), 32'd1);
    tx_en0 = 1'b1;
    cyc();
    chk("reenable_pop", 32'(pop0), 32'd1);
    run_frame(0, 8'h22, 1'b0, 1'b0, 1, 1'b0, 0, "reenable");

    // Reset at cycle 45 of a frame, then a clean frame afterwards.
    q0.push_back(8'h00); refresh();
    cyc();
    chk("rst_frame_pop", 32'(pop0), 32'd1);
    for (int k = 1; k < 45; k++) cyc();
    chk("rst_pre_tx", 32'(tx0), 32'd0);
    q0.push_back(8'h3C); refresh();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_tx", 32'(tx0), 32'd1);
    chk("rst_async_busy", 32'(busy0), 32'd0);
    chk("rst_rd_en", 32'(rd_en0), 32'd0);
    cyc();
    chk("rst_no_pop", 32'(pop0), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_pop", 32'(pop0), 32'd1);
    run_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 0, "post_rst");
    chk("post_rst_busy_after", 32'(busy0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
